// File: rtl/interrupt_injector.sv
// -----------------------------------------------------------------------------
// interrupt_injector
//
// Purpose:
//   Consumer end of the input controller's interrupt-instruction stream.
//   Buffers 32-bit interrupt instructions in a small FIFO and substitutes them
//   into the CPU fetch stream at safe points. The PC is held while an injected
//   instruction is presented. After each injection, a fixed number of
//   pass-through cycles is forced so that normal fetch can make progress.
//
// Configuration macro:
//   IRQ_COALESCE_EN - when defined, a push whose instruction equals the most
//                     recently stored entry (still held in the FIFO) is
//                     consumed without being stored. Such a duplicate never
//                     sets overflow. When undefined, no comparator is built.
//
// Parameters:
//   DEPTH     FIFO entries (power of 2, minimum 2)
//   AW        log2(DEPTH)
//   COOLDOWN  pass-through cycles forced after each injection
//
// Ports:
//   sysclk       in   system clock, all logic on the rising edge
//   reset        in   asynchronous reset, active low
//   irq_instr    in   interrupt instruction from the input controller
//   irq_valid    in   irq_instr is valid this cycle
//   irq_ready    out  FIFO can accept (based on the registered count only)
//   imem_instr   in   instruction fetched from imem
//   stall        in   pipeline stall; freezes injection and cooldown
//   branch_pend  in   control transfer in flight; blocks a new injection
//   cpu_instr    out  instruction presented to decode
//   pc_hold      out  fetch must not advance the PC this cycle
//   injecting    out  cpu_instr is an injected instruction
//   fifo_count   out  current FIFO occupancy, 0..DEPTH
//   overflow     out  sticky flag: a valid was offered while the FIFO was full
// -----------------------------------------------------------------------------
module interrupt_injector #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int COOLDOWN = 3
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic [31:0]   irq_instr,
  input  logic          irq_valid,
  output logic          irq_ready,
  input  logic [31:0]   imem_instr,
  input  logic          stall,
  input  logic          branch_pend,
  output logic [31:0]   cpu_instr,
  output logic          pc_hold,
  output logic          injecting,
  output logic [AW:0]   fifo_count,
  output logic          overflow
);

  localparam int          CW         = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    COOL   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];

  logic full;
  logic dup;
  logic push;
  logic pop;

  // Duplicate detection compares against the last written slot. Because the
  // FIFO pops from the head, the newest entry remains stored as long as the
  // count is nonzero.
`ifdef IRQ_COALESCE_EN
  logic [AW-1:0] last_ptr;
  assign last_ptr = wr_ptr_q - AW'(1);
  assign dup      = (count_q != '0) && (mem_q[last_ptr] == irq_instr);
`else
  assign dup = 1'b0;
`endif

  // Ready depends only on the registered count. A pop in the same cycle
  // therefore does not open a slot early. A zero instruction completes the
  // handshake but is never stored.
  always_comb begin
    full       = (count_q == FULL_COUNT);
    irq_ready  = !full;
    push       = irq_valid && !full && (irq_instr != '0) && !dup;
    overflow_d = overflow_q | (irq_valid & full & ~dup);
  end

  // Injection sequencing: IDLE waits for a safe point, INJECT presents the
  // head until the pipeline is not stalled, and COOL forces pass-through
  // cycles. Stalled cycles do not count toward the cooldown.
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !stall && !branch_pend) begin
          state_d = INJECT;
        end
      end
      INJECT: begin
        if (!stall) begin
          pop = 1'b1;
          if (COOLDOWN == 0) begin
            state_d = IDLE;
          end else begin
            cool_d  = COOL_LOAD;
            state_d = COOL;
          end
        end
      end
      COOL: begin
        if (!stall) begin
          if (cool_q <= CW'(1)) begin
            cool_d  = '0;
            state_d = IDLE;
          end else begin
            cool_d = cool_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cool_d  = '0;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy. Pointers wrap naturally because
  // DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = irq_instr;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all queued instructions.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cool_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cool_q     <= cool_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  // The fetch-side mux is combinational, so pass-through cycles forward
  // imem_instr with no added latency.
  always_comb begin
    injecting  = (state_q == INJECT);
    pc_hold    = (state_q == INJECT);
    cpu_instr  = (state_q == INJECT) ? mem_q[rd_ptr_q] : imem_instr;
    fifo_count = count_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_interrupt_injector.sv
// -----------------------------------------------------------------------------
// tb_interrupt_injector
//
// Purpose:
//   Drives interrupt_injector with directed scenarios followed by randomized
//   traffic. A queue-based reference model predicts the outputs for every
//   cycle, and a separate monitor compares the DUT against those predictions.
// -----------------------------------------------------------------------------
module tb_interrupt_injector;

  localparam int DEPTH    = 4;
  localparam int AW       = 2;
  localparam int COOLDOWN = 3;

  typedef struct {
    logic [31:0] cpu;
    logic        ready;
    logic        hold;
    logic        inj;
    logic [AW:0] cnt;
    logic        ovf;
  } exp_t;

  logic          sysclk;
  logic          reset;
  logic [31:0]   irq_instr;
  logic          irq_valid;
  logic          irq_ready;
  logic [31:0]   imem_instr;
  logic          stall;
  logic          branch_pend;
  logic [31:0]   cpu_instr;
  logic          pc_hold;
  logic          injecting;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cycleIdx    = 0;

  exp_t expQ[$];

  // The reference model is a plain instruction queue plus an "injection
  // showing" flag and a count of forced pass-through cycles still owed.
  logic [31:0] modelQ[$];
  bit          modelShowing;
  int          modelGap;
  bit          modelOvf;

  interrupt_injector #(
    .DEPTH(DEPTH),
    .AW(AW),
    .COOLDOWN(COOLDOWN)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .irq_instr(irq_instr),
    .irq_valid(irq_valid),
    .irq_ready(irq_ready),
    .imem_instr(imem_instr),
    .stall(stall),
    .branch_pend(branch_pend),
    .cpu_instr(cpu_instr),
    .pc_hold(pc_hold),
    .injecting(injecting),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  // Free-running system clock.
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Drives one cycle of inputs just after the rising edge, records the
  // model's prediction for that cycle, and then advances the model across
  // the next rising edge.
  task automatic applyStimulus(input logic rstn, input logic v,
                               input logic [31:0] instr,
                               input logic [31:0] imem,
                               input logic st, input logic bp);
    exp_t e;
    bit   full;
    bit   dup;
    bit   store;
    int   sizeBefore;
    @(posedge sysclk);
    #1;
    reset       = rstn;
    irq_valid   = v;
    irq_instr   = instr;
    imem_instr  = imem;
    stall       = st;
    branch_pend = bp;
    cycleIdx++;
    if (!rstn) begin
      modelQ.delete();
      modelShowing = 0;
      modelGap     = 0;
      modelOvf     = 0;
      e.cpu   = imem;
      e.ready = 1'b1;
      e.hold  = 1'b0;
      e.inj   = 1'b0;
      e.cnt   = '0;
      e.ovf   = 1'b0;
      expQ.push_back(e);
      return;
    end
    sizeBefore = modelQ.size();
    full       = (sizeBefore == DEPTH);
    e.ready = !full;
    e.cnt   = (AW + 1)'(sizeBefore);
    e.ovf   = modelOvf;
    e.hold  = modelShowing;
    e.inj   = modelShowing;
    e.cpu   = modelShowing ? modelQ[0] : imem;
    expQ.push_back(e);

    dup = 0;
`ifdef IRQ_COALESCE_EN
    dup = (sizeBefore > 0) && (modelQ[sizeBefore-1] == instr);
`endif
    store = v && !full && (instr != 32'h0) && !dup;
    if (v && full && !dup) modelOvf = 1;

    if (modelShowing) begin
      if (!st) begin
        void'(modelQ.pop_front());
        modelShowing = 0;
        modelGap     = COOLDOWN;
      end
    end else if (modelGap > 0) begin
      if (!st) modelGap--;
    end else if (sizeBefore != 0 && !st && !bp) begin
      modelShowing = 1;
    end
    if (store) modelQ.push_back(instr);
  endtask

  task automatic idleCycles(input int n, input logic st, input logic bp);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, $urandom, st, bp);
    end
  endtask

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h",
               name, cycleIdx, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("cpu_instr",  cpu_instr,          e.cpu);
    checkField("irq_ready",  {31'h0, irq_ready}, {31'h0, e.ready});
    checkField("pc_hold",    {31'h0, pc_hold},   {31'h0, e.hold});
    checkField("injecting",  {31'h0, injecting}, {31'h0, e.inj});
    checkField("fifo_count", 32'(fifo_count),    32'(e.cnt));
    checkField("overflow",   {31'h0, overflow},  {31'h0, e.ovf});
  endtask

  // Monitor: on every falling edge, compares the DUT against the oldest
  // prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    logic [31:0] pool [6];
    logic [31:0] val;
    reset       = 1'b0;
    irq_valid   = 1'b0;
    irq_instr   = 32'h0;
    imem_instr  = 32'h1234_5678;
    stall       = 1'b0;
    branch_pend = 1'b0;
    modelShowing = 0;
    modelGap     = 0;
    modelOvf     = 0;

    // Reset held low for three cycles, then released.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 1'b0);

    // A single push, followed by the injection and cooldown.
    applyStimulus(1'b1, 1'b1, 32'hC000_0001, $urandom, 1'b0, 1'b0);
    idleCycles(7, 1'b0, 1'b0);

    // Five back-to-back pushes while stalled: the fifth overflows.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, 32'hA000_0010 + 32'(i), $urandom, 1'b1, 1'b0);
    idleCycles(22, 1'b0, 1'b0);

    // Stall held for five cycles while an injection is showing.
    applyStimulus(1'b1, 1'b1, 32'hB000_0001, $urandom, 1'b0, 1'b0);
    idleCycles(1, 1'b0, 1'b0);
    idleCycles(5, 1'b1, 1'b0);
    idleCycles(6, 1'b0, 1'b0);

    // branch_pend blocks injection while two entries are queued.
    applyStimulus(1'b1, 1'b1, 32'hD000_0001, $urandom, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hD000_0002, $urandom, 1'b0, 1'b1);
    idleCycles(4, 1'b0, 1'b1);
    idleCycles(12, 1'b0, 1'b0);

    // A zero instruction, then the same value twice.
    applyStimulus(1'b1, 1'b1, 32'h0000_0000, $urandom, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hC000_0002, $urandom, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hC000_0002, $urandom, 1'b1, 1'b0);
    idleCycles(1, 1'b1, 1'b0);
    idleCycles(12, 1'b0, 1'b0);

    // Reset while an injection is showing, with three entries queued.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 32'hE000_0001 + 32'(i), $urandom, 1'b1, 1'b0);
    idleCycles(1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, $urandom, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, $urandom, 1'b0, 1'b0);
    idleCycles(3, 1'b0, 1'b0);

    // Randomized traffic: a small value pool makes zeros and repeats common.
    pool[0] = 32'hC000_0001;
    pool[1] = 32'hC000_0002;
    pool[2] = 32'hC000_0003;
    pool[3] = 32'h0000_0000;
    pool[4] = 32'h8000_0000;
    pool[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 70) val = pool[$urandom_range(5)];
      else val = $urandom;
      applyStimulus(($urandom_range(199) != 0),
                    ($urandom_range(99) < 45), val, $urandom,
                    ($urandom_range(99) < 25), ($urandom_range(99) < 20));
    end
    idleCycles(2, 1'b0, 1'b0);

    @(negedge sysclk);
    #1;
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d predictions left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
